// File: rtl/mips_alu_pkg.sv
// Shared opcode/state types and helpers for the sequential MIPS ALU.
package mips_alu_pkg;

   localparam int unsigned OP_W = 4;

   typedef enum logic [OP_W-1:0] {
      OP_AND   = 4'b0000,
      OP_OR    = 4'b0001,
      OP_ADD   = 4'b0010,
      OP_MFHI  = 4'b0011,
      OP_MFLO  = 4'b0100,
      OP_SUB   = 4'b0110,
      OP_SLT   = 4'b0111,
      OP_MULT  = 4'b1000,
      OP_MULTU = 4'b1001,
      OP_DIV   = 4'b1010,
      OP_DIVU  = 4'b1011,
      OP_NOR   = 4'b1100
   } alu_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } muldiv_state_e;

   function automatic logic is_muldiv(input alu_op_e op);
      return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
   endfunction

   function automatic logic is_div(input alu_op_e op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

   function automatic logic is_signed_op(input alu_op_e op);
      return (op == OP_MULT) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/mips_muldiv_core.sv
// Iterative radix-2 multiplier / restoring divider working on magnitudes,
// with the sign of signed results restored in a single FIX cycle.
module mips_muldiv_core
   import mips_alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  alu_op_e          op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             ready_o,
   output logic             done_c,
   output logic [WIDTH-1:0] hi_c,
   output logic [WIDTH-1:0] lo_c,
   output logic             dbz_c
);

   localparam int unsigned CW = $clog2(WIDTH);
   localparam int unsigned PW = 2 * WIDTH;

   muldiv_state_e    state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   alu_op_e          op_q, op_d;
   logic [PW-1:0]    acc_q, acc_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic             neg_q, neg_d;
   logic             aneg_q, aneg_d;
   logic             dbz_q, dbz_d;
   logic             ready_q;

   logic             a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH:0]   mul_sum, div_sh, div_diff;
   logic             div_ge;
   logic [PW-1:0]    prod;

   assign ready_o = ready_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         op_q    <= OP_AND;
         acc_q   <= '0;
         mcand_q <= '0;
         a_q     <= '0;
         neg_q   <= 1'b0;
         aneg_q  <= 1'b0;
         dbz_q   <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         acc_q   <= acc_d;
         mcand_q <= mcand_d;
         a_q     <= a_d;
         neg_q   <= neg_d;
         aneg_q  <= aneg_d;
         dbz_q   <= dbz_d;
         ready_q <= (state_d == IDLE) || (state_d == DONE);
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      acc_d   = acc_q;
      mcand_d = mcand_q;
      a_d     = a_q;
      neg_d   = neg_q;
      aneg_d  = aneg_q;
      dbz_d   = dbz_q;
      done_c  = 1'b0;
      hi_c    = acc_q[PW-1:WIDTH];
      lo_c    = acc_q[WIDTH-1:0];
      dbz_c   = dbz_q;
      prod    = acc_q;

      a_neg = is_signed_op(op_i) & a_i[WIDTH-1];
      b_neg = is_signed_op(op_i) & b_i[WIDTH-1];
      a_mag = a_neg ? -a_i : a_i;
      b_mag = b_neg ? -b_i : b_i;

      // One shift-add (mul) or restoring-subtract (div) step on the {HI,LO} accumulator
      mul_sum  = {1'b0, acc_q[PW-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
      div_sh   = {acc_q[PW-1:WIDTH], acc_q[WIDTH-1]};
      div_ge   = div_sh >= {1'b0, mcand_q};
      div_diff = div_sh - {1'b0, mcand_q};

      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (start_i) begin
               state_d = ITER;
               cnt_d   = CW'(WIDTH - 1);
               op_d    = op_i;
               a_d     = a_i;
               aneg_d  = a_neg;
               neg_d   = a_neg ^ b_neg;
               dbz_d   = is_div(op_i) && (b_i == '0);
               if (is_div(op_i)) begin
                  acc_d   = {{WIDTH{1'b0}}, a_mag};
                  mcand_d = b_mag;
               end else begin
                  acc_d   = {{WIDTH{1'b0}}, b_mag};
                  mcand_d = a_mag;
               end
            end
         end
         ITER: begin
            if (!dbz_q) begin
               if (is_div(op_q)) begin
                  acc_d = {(div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0]),
                           acc_q[WIDTH-2:0], div_ge};
               end else begin
                  acc_d = {mul_sum, acc_q[WIDTH-1:1]};
               end
            end
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == '0) begin
               state_d = FIX;
               cnt_d   = '0;
            end
         end
         FIX: begin
            state_d = DONE;
            done_c  = 1'b1;
            if (dbz_q) begin
               lo_c = '1;
               hi_c = a_q;
            end else if (is_div(op_q)) begin
               lo_c = neg_q  ? -acc_q[WIDTH-1:0]     : acc_q[WIDTH-1:0];
               hi_c = aneg_q ? -acc_q[PW-1:WIDTH]    : acc_q[PW-1:WIDTH];
            end else begin
               prod = neg_q ? -acc_q : acc_q;
               hi_c = prod[PW-1:WIDTH];
               lo_c = prod[WIDTH-1:0];
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: rtl/mips_seq_alu.sv
// Clocked MIPS ALU: single-cycle logic/arith ops plus iterative mul/div into HI/LO.
module mips_seq_alu
   import mips_alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [OP_W-1:0]  opCode,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             ready,
   output logic             valid,
   output logic [WIDTH-1:0] ALU_Out,
   output logic             zero,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO,
   output logic             div_by_zero
);

   alu_op_e          op;
   logic             accept;
   logic             md_done, md_dbz;
   logic [WIDTH-1:0] md_hi, md_lo;
   logic [WIDTH-1:0] logic_res;

   logic             valid_q, valid_d;
   logic [WIDTH-1:0] alu_q, alu_d;
   logic             zero_q, zero_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             dbz_q, dbz_d;

   assign op     = alu_op_e'(opCode);
   assign accept = start & ready;

   assign valid       = valid_q;
   assign ALU_Out     = alu_q;
   assign zero        = zero_q;
   assign HI          = hi_q;
   assign LO          = lo_q;
   assign div_by_zero = dbz_q;

   mips_muldiv_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .clk     (clk),
      .rst_n   (rst_n),
      .start_i (accept & is_muldiv(op)),
      .op_i    (op),
      .a_i     (A),
      .b_i     (B),
      .ready_o (ready),
      .done_c  (md_done),
      .hi_c    (md_hi),
      .lo_c    (md_lo),
      .dbz_c   (md_dbz)
   );

   // Single-cycle result; unlisted opcodes fall through to zero
   always_comb begin
      logic_res = '0;
      case (op)
         OP_AND:  logic_res = A & B;
         OP_OR:   logic_res = A | B;
         OP_ADD:  logic_res = A + B;
         OP_SUB:  logic_res = A - B;
         OP_SLT:  logic_res = WIDTH'($signed(A) < $signed(B));
         OP_NOR:  logic_res = ~(A | B);
         OP_MFHI: logic_res = hi_q;
         OP_MFLO: logic_res = lo_q;
         default: logic_res = '0;
      endcase
   end

   always_comb begin
      valid_d = 1'b0;
      alu_d   = alu_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      dbz_d   = 1'b0;
      if (md_done) begin
         valid_d = 1'b1;
         alu_d   = md_lo;
         hi_d    = md_hi;
         lo_d    = md_lo;
         dbz_d   = md_dbz;
      end else if (accept && !is_muldiv(op)) begin
         valid_d = 1'b1;
         alu_d   = logic_res;
      end
      zero_d = (alu_d == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         alu_q   <= '0;
         zero_q  <= 1'b1;
         hi_q    <= '0;
         lo_q    <= '0;
         dbz_q   <= 1'b0;
      end else begin
         valid_q <= valid_d;
         alu_q   <= alu_d;
         zero_q  <= zero_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         dbz_q   <= dbz_d;
      end
   end

endmodule

// File: tb/tb_mips_seq_alu.sv
// Scoreboard bench for mips_seq_alu: issue-side reference model, valid-side monitor.
module tb_mips_seq_alu;

   localparam int unsigned W = 32;

   typedef struct {
      logic [W-1:0] alu;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dbz;
      int           cyc;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [3:0]   opCode = 4'd0;
   logic [W-1:0] A = '0, B = '0;
   logic         ready, valid, zero, div_by_zero;
   logic [W-1:0] ALU_Out, HI, LO;

   exp_t         sbq[$];
   logic [W-1:0] mhi = '0, mlo = '0;
   int           cyc = 0;
   int           cmps = 0;
   int           errs = 0;

   mips_seq_alu #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .opCode(opCode), .A(A), .B(B),
      .ready(ready), .valid(valid), .ALU_Out(ALU_Out), .zero(zero),
      .HI(HI), .LO(LO), .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      cmps++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic is_md(input logic [3:0] op);
      return op inside {4'b1000, 4'b1001, 4'b1010, 4'b1011};
   endfunction

   // Reference model from the architectural rules, using 64-bit arithmetic
   function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t        e;
      longint      sa, sb;
      logic [63:0] t, u;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      e.dbz = 1'b0;
      e.alu = '0;
      case (op)
         4'b0000: e.alu = a & b;
         4'b0001: e.alu = a | b;
         4'b0010: e.alu = a + b;
         4'b0110: e.alu = a - b;
         4'b0111: e.alu = (sa < sb) ? 32'd1 : 32'd0;
         4'b1100: e.alu = ~(a | b);
         4'b0011: e.alu = mhi;
         4'b0100: e.alu = mlo;
         4'b1000: begin t = 64'(sa * sb); mhi = t[63:32]; mlo = t[31:0]; end
         4'b1001: begin t = {32'd0, a} * {32'd0, b}; mhi = t[63:32]; mlo = t[31:0]; end
         4'b1010, 4'b1011: begin
            if (b == '0) begin
               e.dbz = 1'b1; mlo = '1; mhi = a;
            end else if (op == 4'b1010) begin
               t = 64'(sa / sb); u = 64'(sa % sb); mlo = t[31:0]; mhi = u[31:0];
            end else begin
               mlo = a / b; mhi = a % b;
            end
         end
         default: e.alu = '0;
      endcase
      if (is_md(op)) e.alu = mlo;
      e.hi  = mhi;
      e.lo  = mlo;
      e.cyc = cyc + (is_md(op) ? W + 2 : 1);
      return e;
   endfunction

   task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      int n = 0;
      while (!ready && n < 100) begin @(negedge clk); n++; end
      if (!ready) check("issue_ready_timeout", 64'(ready), 64'd1);
      start = 1'b1; opCode = op; A = a; B = b;
      sbq.push_back(model(op, a, b));
      @(negedge clk);
      start = 1'b0; opCode = 4'($urandom); A = $urandom; B = $urandom;
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 7))
         0: return '0;
         1: return 32'h8000_0000;
         2: return '1;
         3: return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   // Monitor: every valid pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (rst_n && valid) begin
         if (sbq.size() == 0) begin
            check("unexpected_valid", 64'(valid), 64'd0);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            check("alu_out", 64'(ALU_Out), 64'(e.alu));
            check("zero", 64'(zero), 64'(e.alu == '0));
            check("hi", 64'(HI), 64'(e.hi));
            check("lo", 64'(LO), 64'(e.lo));
            check("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
            check("valid_cycle", 64'(cyc), 64'(e.cyc));
            check("ready_at_valid", 64'(ready), 64'd1);
         end
      end
   end

   initial begin
      int n;
      repeat (3) @(negedge clk);
      check("rst_ready", 64'(ready), 64'd1);
      check("rst_valid", 64'(valid), 64'd0);
      check("rst_alu", 64'(ALU_Out), 64'd0);
      check("rst_zero", 64'(zero), 64'd1);
      check("rst_hilo", {HI, LO}, 64'd0);
      check("rst_dbz", 64'(div_by_zero), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Single-cycle back-to-back, SLT sign handling
      issue(4'b0010, 32'd1000, 32'd200);
      issue(4'b0110, 32'd1000, 32'd1000);
      issue(4'b0111, 32'hFFFF_FFFB, 32'd3);
      issue(4'b0111, 32'd3, 32'hFFFF_FFFB);

      // Mul/div directed corners
      issue(4'b1000, 32'hFFFF_FFFD, 32'd7);
      issue(4'b1001, 32'hFFFF_FFFF, 32'd2);
      issue(4'b0011, 32'd0, 32'd0);
      issue(4'b1010, 32'hFFFF_FFF9, 32'd2);
      issue(4'b1010, 32'h8000_0000, 32'hFFFF_FFFF);
      issue(4'b1011, 32'd1000, 32'd0);
      issue(4'b0100, 32'd0, 32'd0);

      // Asynchronous reset in the middle of a multiply
      issue(4'b1000, 32'd12345, 32'd678);
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_ready", 64'(ready), 64'd1);
      check("midrst_valid", 64'(valid), 64'd0);
      check("midrst_hilo", {HI, LO}, 64'd0);
      check("midrst_alu", 64'(ALU_Out), 64'd0);
      sbq.delete();
      mhi = '0; mlo = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      issue(4'b0010, 32'd1, 32'd1);

      // Held ADD start during a DIVU busy window must be ignored
      issue(4'b1011, 32'd100003, 32'd17);
      n = 0;
      while (!ready && n < 100) begin
         start = 1'b1; opCode = 4'b0010; A = $urandom; B = $urandom;
         @(negedge clk); n++;
      end
      start = 1'b0;
      issue(4'b0100, 32'd0, 32'd0);

      // Randomised mix including unlisted opcodes
      for (int i = 0; i < 60; i++) begin
         issue(4'($urandom_range(0, 15)), pick(), pick());
      end

      n = 0;
      while (sbq.size() != 0 && n < 200) begin @(negedge clk); n++; end
      check("drain_outstanding", 64'(sbq.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
      $finish;
   end

endmodule
